// File: rtl/seq_ctrl_gen_pkg.sv
// Shared types and constants for the seq_ctrl_gen controller.
// State encoding and status-code bit positions live here so that the FSM
// and anything decoding `code` agree on one definition.
package seq_ctrl_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Bit positions inside the registered status code
  localparam int CODE_IDLE_B  = 0;
  localparam int CODE_RUN_B   = 1;
  localparam int CODE_DONE_B  = 2;
  localparam int CODE_CNT_LSB = 3;

endpackage

// File: rtl/seq_ctrl_cnt.sv
// Run-length counter for seq_ctrl_gen.
// Holds the terminal value (loaded on accept) and the running count.
// q_nxt exposes the value q takes at the next edge so the FSM can
// register a status code that matches the count in the same cycle.
module seq_ctrl_cnt #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] q,
  output logic [CNT_W-1:0] q_nxt,
  output logic             tc
);

  logic [CNT_W-1:0] term;

  // Next count: clear wins over increment; no wrap guard needed since the
  // FSM stops enabling once the terminal compare fires.
  always_comb begin
    q_nxt = q;
    if (rst || clr)
      q_nxt = '0;
    else if (en)
      q_nxt = q + CNT_W'(1);
  end

  // Count and terminal-value registers
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      term <= '0;
    end else begin
      q <= q_nxt;
      if (load)
        term <= load_val;
    end
  end

  assign tc = (q == term);

endmodule

// File: rtl/seq_ctrl_gen.sv
// seq_ctrl_gen: start/stop/pause run controller with one-shot and
// auto-repeat modes. All outputs are registered from next-state/next-count.
// Optional build macro SEQ_CTRL_GEN_WATCHDOG_EN adds a HOLD-state watchdog
// that aborts to IDLE after 2^CNT_W cycles in HOLD and pulses wd_err.
module seq_ctrl_gen
  import seq_ctrl_gen_pkg::*;
#(
  parameter int CNT_W      = 6,
  parameter int CODE_W     = 7,
  parameter bit REPEAT_DEF = 1'b0
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              repeat_i,
  input  logic              pause,
  input  logic              stop,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cnt,
  output logic [CODE_W-1:0] code
`ifdef SEQ_CTRL_GEN_WATCHDOG_EN
  ,
  output logic              wd_err
`endif
);

  state_t             state, state_nxt;
  logic               rep_r;
  logic               accept;
  logic               cnt_clr, cnt_en, tc;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [CODE_W-1:0]  code_nxt;
  logic               wd_exp;

  assign accept = (state == ST_IDLE) && start;

`ifdef SEQ_CTRL_GEN_WATCHDOG_EN
  logic [CNT_W-1:0] wd_cnt;

  // Expiry on the 2^CNT_W-th consecutive HOLD cycle
  assign wd_exp = (state == ST_HOLD) && (wd_cnt == '1);

  // Watchdog counter runs only while staying in HOLD; wd_err marks the abort
  always_ff @(posedge CK) begin
    if (RST) begin
      wd_cnt <= '0;
      wd_err <= 1'b0;
    end else begin
      wd_cnt <= (state == ST_HOLD && state_nxt == ST_HOLD) ? wd_cnt + CNT_W'(1) : '0;
      wd_err <= wd_exp && pause && !stop;
    end
  end
`else
  assign wd_exp = 1'b0;
`endif

  // Next-state and counter control; stop outranks pause, pause outranks
  // terminal count
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        cnt_clr   = 1'b1;
        state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (stop)       state_nxt = ST_IDLE;
        else if (pause) state_nxt = ST_HOLD;
        else if (tc)    state_nxt = ST_DONE;
        else            cnt_en    = 1'b1;
      end
      ST_HOLD: begin
        if (stop)        state_nxt = ST_IDLE;
        else if (!pause) state_nxt = ST_RUN;
        else if (wd_exp) state_nxt = ST_IDLE;
      end
      ST_DONE: state_nxt = (stop || !rep_r) ? ST_IDLE : ST_LOAD;
      default: state_nxt = ST_IDLE;
    endcase
  end

  seq_ctrl_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (CK),
    .rst      (RST),
    .load     (accept),
    .load_val (len),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .q        (cnt),
    .q_nxt    (cnt_nxt),
    .tc       (tc)
  );

  // Count field of the status code: zero-extend or truncate next count
  if (CODE_W > CODE_CNT_LSB) begin : g_code_cnt
    localparam int CB = CODE_W - CODE_CNT_LSB;
    logic [CB+CNT_W-1:0] cnt_ext;
    assign cnt_ext = {{CB{1'b0}}, cnt_nxt};
    assign code_nxt[CODE_W-1:CODE_CNT_LSB] = cnt_ext[CB-1:0];
  end

  assign code_nxt[CODE_IDLE_B] = (state_nxt == ST_IDLE);
  assign code_nxt[CODE_RUN_B]  = (state_nxt == ST_RUN) || (state_nxt == ST_HOLD);
  assign code_nxt[CODE_DONE_B] = (state_nxt == ST_DONE);

  // State, mode and registered status outputs
  always_ff @(posedge CK) begin
    if (RST) begin
      state <= ST_IDLE;
      rep_r <= REPEAT_DEF;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      code  <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        rep_r <= repeat_i;
      ready <= (state_nxt == ST_IDLE);
      busy  <= (state_nxt == ST_LOAD) || (state_nxt == ST_RUN) || (state_nxt == ST_HOLD);
      done  <= (state_nxt == ST_DONE);
      code  <= code_nxt;
    end
  end

endmodule

// File: tb/tb_seq_ctrl_gen.sv
// Self-checking bench for seq_ctrl_gen: directed latency/boundary scenarios
// plus a randomized phase, all compared cycle by cycle to a phase model.
module tb_seq_ctrl_gen;

  localparam int CNT_W  = 6;
  localparam int CODE_W = 7;

  logic              CK = 1'b0;
  logic              RST, start, repeat_i, pause, stop;
  logic [CNT_W-1:0]  len;
  logic              ready, busy, done;
  logic [CNT_W-1:0]  cnt;
  logic [CODE_W-1:0] code;
`ifdef SEQ_CTRL_GEN_WATCHDOG_EN
  logic              wd_err;
`endif

  seq_ctrl_gen #(.CNT_W(CNT_W), .CODE_W(CODE_W), .REPEAT_DEF(1'b0)) dut (
    .CK       (CK),
    .RST      (RST),
    .start    (start),
    .len      (len),
    .repeat_i (repeat_i),
    .pause    (pause),
    .stop     (stop),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .cnt      (cnt),
    .code     (code)
`ifdef SEQ_CTRL_GEN_WATCHDOG_EN
    ,
    .wd_err   (wd_err)
`endif
  );

  always #5 CK = ~CK;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t0     = 0;
  bit cmp_en = 1'b1;

  // Reference model: the run phase plus the quantities the rules talk about
  typedef enum {P_IDLE, P_LOAD, P_RUN, P_HOLD, P_DONE} ph_t;
  ph_t ph     = P_IDLE;
  int  m_cnt  = 0;
  int  m_len  = 0;
  bit  m_rep  = 1'b0;
  bit  m_rst  = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare
  task automatic tick();
    int ec;
    @(posedge CK);
    cyc++;
    if (RST) begin
      ph = P_IDLE; m_cnt = 0; m_len = 0; m_rep = 1'b0; m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      case (ph)
        P_IDLE: if (start) begin m_len = int'(len); m_rep = repeat_i; ph = P_LOAD; end
        P_LOAD: begin m_cnt = 0; ph = P_RUN; end
        P_RUN: begin
          if (stop)                ph = P_IDLE;
          else if (pause)          ph = P_HOLD;
          else if (m_cnt == m_len) ph = P_DONE;
          else                     m_cnt = m_cnt + 1;
        end
        P_HOLD: begin
          if (stop)        ph = P_IDLE;
          else if (!pause) ph = P_RUN;
        end
        P_DONE: ph = (stop || !m_rep) ? P_IDLE : P_LOAD;
      endcase
    end
    #1;
    if (cmp_en) begin
      ec = m_rst ? 0 : ((ph == P_IDLE) ? 1 : 0) + ((ph == P_RUN || ph == P_HOLD) ? 2 : 0)
                     + ((ph == P_DONE) ? 4 : 0) + 8 * (m_cnt % 16);
      chk("ready", ready, (ph == P_IDLE));
      chk("busy",  busy,  (ph == P_LOAD || ph == P_RUN || ph == P_HOLD));
      chk("done",  done,  (ph == P_DONE));
      chk("cnt",   cnt,   m_cnt);
      chk("code",  code,  ec);
    end
  endtask

  task automatic accept(input int l, input bit r);
    start = 1'b1; len = CNT_W'(l); repeat_i = r;
    tick();
    start = 1'b0;
    t0 = cyc;
  endtask

  // Cycle index of the done pulse, counting the accept edge as edge 0
  task automatic wait_done(output int idx);
    int n = 0;
    do begin tick(); n++; end while (!done && n < 300);
    if (!done) chk("done_timeout", 0, 1);
    idx = cyc - t0 + 1;
  endtask

  task automatic wait_run_cnt(input int v);
    int n = 0;
    while (!(code[1] && cnt == CNT_W'(v)) && n < 300) begin tick(); n++; end
    if (n >= 300) chk("run_cnt_timeout", 0, 1);
  endtask

  initial begin
    int idx, d0;
    RST = 1'b1; start = 1'b0; len = '0; repeat_i = 1'b0; pause = 1'b0; stop = 1'b0;
    repeat (3) tick();
    chk("rst_ready", ready, 1);
    chk("rst_code", code, 0);
    RST = 1'b0;
    tick();
    chk("idle_code", code, 7'b0000001);

    // One-shot len=5: done at cycle N+3, ready at N+4
    accept(5, 1'b0);
    chk("load_busy", busy, 1);
    wait_done(idx);
    chk("lat_len5", idx, 8);
    tick();
    chk("ready_after_done", ready, 1);

    // Auto-repeat len=3: period 6, then stop mid-run
    accept(3, 1'b1);
    wait_done(idx);
    chk("rep_first", idx, 6);
    d0 = cyc; wait_done(idx); chk("rep_period1", cyc - d0, 6);
    d0 = cyc; wait_done(idx); chk("rep_period2", cyc - d0, 6);
    wait_run_cnt(2);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_ready", ready, 1);
    chk("stop_no_done", done, 0);

    // Pause 3 cycles at cnt=2 delays done by 4
    accept(4, 1'b0);
    wait_run_cnt(2);
    pause = 1'b1; repeat (3) tick(); pause = 1'b0;
    wait_done(idx);
    chk("pause_delay", idx, 4 + 3 + 4);
    tick();

    // Length boundaries
    accept(0, 1'b0);
    wait_done(idx);
    chk("lat_len0", idx, 3);
    tick();
    accept(63, 1'b0);
    wait_done(idx);
    chk("lat_len63", idx, 66);
    chk("max_cnt", cnt, 63);
    tick();

    // Reset in the middle of a run
    accept(10, 1'b0);
    wait_run_cnt(3);
    RST = 1'b1; tick(); RST = 1'b0;
    chk("midrst_ready", ready, 1);
    chk("midrst_cnt", cnt, 0);
    chk("midrst_done", done, 0);
    tick();

    // Randomized control traffic
    repeat (3000) begin
      RST      = ($urandom_range(0, 299) == 0);
      start    = ($urandom_range(0, 1) == 0);
      len      = ($urandom_range(0, 3) == 0) ? CNT_W'($urandom) : CNT_W'($urandom_range(0, 7));
      repeat_i = $urandom_range(0, 1) == 0;
      pause    = ($urandom_range(0, 4) == 0);
      stop     = ($urandom_range(0, 15) == 0);
      tick();
    end
    RST = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
    tick();
    RST = 1'b0;
    tick();

`ifdef SEQ_CTRL_GEN_WATCHDOG_EN
    begin
      int seen = 0;
      accept(5, 1'b0);
      wait_run_cnt(1);
      pause = 1'b1; cmp_en = 1'b0;
      repeat (80) begin
        tick();
        if (wd_err) begin seen++; chk("wd_ready", ready, 1); end
      end
      chk("wd_pulses", seen, 1);
      pause = 1'b0; RST = 1'b1; tick(); RST = 1'b0; cmp_en = 1'b1;
      tick();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
